// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the parametrised FIFO
package fifo_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Flag bundle for reuse by monitors and assertions.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is never reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised single-clock FIFO with flags, error pulses and optional FWFT
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of 2 and >= 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, underflow_q;
  logic [PW-1:0] count_w;
  logic          rd_accept, wr_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status_t  status;

  // Count and flags come only from registered pointers and error registers.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign status  = '{
    empty:        (count_w == '0),
    full:         (count_w == DEPTH_C),
    almost_empty: (count_w <= AE_C),
    almost_full:  (count_w >= AF_C),
    overflow:     overflow_q,
    underflow:    underflow_q
  };

  assign empty        = status.empty;
  assign full         = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_w;

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_accept = rd_en && !status.empty;
  assign wr_accept = wr_en && (!status.full || rd_accept);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept && rst_n),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Next pointer values: advance only on accepted requests.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer and error-pulse registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= wr_en && !wr_accept;
      underflow_q <= rd_en && !rd_accept;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented straight from the RAM at the registered read pointer.
    assign data_out = mem_rdata;
    assign rd_valid = !status.empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;

    // Registered read: capture the head word on an accepted read, hold otherwise.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_out_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) data_out_q <= mem_rdata;
      end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param
module tb_fifo_param;

  localparam int DW = 8;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          wr_en, rd_en;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_vld, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic          f_vld, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [3:0]    s_cnt, f_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(s_dout), .rd_valid(s_vld), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(f_dout), .rd_valid(f_vld), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_empty"}, int'(s_empty), 1);
    check({tag, "_ae"},    int'(s_ae),    1);
    check({tag, "_full"},  int'(s_full),  0);
    check({tag, "_af"},    int'(s_af),    0);
    check({tag, "_count"}, int'(s_cnt),   0);
    check({tag, "_dout"},  int'(s_dout),  0);
    check({tag, "_vld"},   int'(s_vld),   0);
    check({tag, "_ovf"},   int'(s_ovf),   0);
    check({tag, "_unf"},   int'(s_unf),   0);
    check({tag, "_fvld"},  int'(f_vld),   0);
  endtask

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_v;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    #1;
    cyc(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0);
    check_idle_reset("reset");

    // Fill 1..8 watching count and threshold flags on the way up.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      check($sformatf("fill_count_%0d", i), int'(s_cnt), i);
      check($sformatf("fill_af_%0d", i), int'(s_af), (i >= 6) ? 1 : 0);
      check($sformatf("fill_ae_%0d", i), int'(s_ae), (i <= 2) ? 1 : 0);
    end
    check("full_after_8", int'(s_full), 1);
    check("f_head_full", int'(f_dout), 1);

    // Ninth write while full is rejected with a single overflow pulse.
    cyc(1'b1, 1'b0, 8'd9);
    check("ovf_pulse", int'(s_ovf), 1);
    check("ovf_count", int'(s_cnt), 8);
    cyc(1'b0, 1'b0, '0);
    check("ovf_clear", int'(s_ovf), 0);

    // Drain: data one cycle after rd_en, flags on the way down.
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("fwft_head_%0d", i), int'(f_dout), i);
      cyc(1'b0, 1'b1, '0);
      check($sformatf("rd_data_%0d", i), int'(s_dout), i);
      check($sformatf("rd_vld_%0d", i), int'(s_vld), 1);
      check($sformatf("drain_count_%0d", i), int'(s_cnt), 8 - i);
      check($sformatf("drain_af_%0d", i), int'(s_af), (8 - i >= 6) ? 1 : 0);
      check($sformatf("drain_ae_%0d", i), int'(s_ae), (8 - i <= 2) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, '0);
    check("idle_vld", int'(s_vld), 0);
    check("idle_hold", int'(s_dout), 8);
    check("drained_empty", int'(s_empty), 1);

    // Full FIFO with simultaneous read and write across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, DW'(10 + i));
      model_q.push_back(DW'(10 + i));
    end
    for (int k = 0; k < 20; k++) begin
      exp_v = model_q.pop_front();
      model_q.push_back(DW'(100 + k));
      cyc(1'b1, 1'b1, DW'(100 + k));
      check($sformatf("rw_data_%0d", k), int'(s_dout), int'(exp_v));
      check($sformatf("rw_count_%0d", k), int'(s_cnt), 8);
      check($sformatf("rw_ovf_%0d", k), int'(s_ovf), 0);
      check($sformatf("rw_full_%0d", k), int'(s_full), 1);
    end
    for (int i = 0; i < 8; i++) begin
      exp_v = model_q.pop_front();
      cyc(1'b0, 1'b1, '0);
      check($sformatf("rw_drain_%0d", i), int'(s_dout), int'(exp_v));
    end
    check("rw_empty", int'(s_empty), 1);

    // Simultaneous read and write on empty: write only, underflow pulses.
    cyc(1'b1, 1'b1, 8'h1A);
    check("emp_rw_unf", int'(s_unf), 1);
    check("emp_rw_count", int'(s_cnt), 1);
    check("emp_rw_vld", int'(s_vld), 0);
    check("emp_rw_fdout", int'(f_dout), 8'h1A);
    check("emp_rw_fvld", int'(f_vld), 1);
    check("emp_rw_funf", int'(f_unf), 1);
    cyc(1'b0, 1'b1, '0);
    check("emp_rw_rd", int'(s_dout), 8'h1A);
    check("emp_rw_rdvld", int'(s_vld), 1);
    check("emp_rw_unf_clr", int'(s_unf), 0);
    check("emp_rw_cnt0", int'(s_cnt), 0);

    // Mid-operation reset alongside a write discards everything.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, DW'(40 + i));
    check("pre_rst_count", int'(s_cnt), 5);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 8'h77);
    rst_n = 1'b1;
    check_idle_reset("midrst");
    check("midrst_fcount", int'(f_cnt), 0);
    cyc(1'b0, 1'b1, '0);
    check("post_rst_unf", int'(s_unf), 1);
    check("post_rst_vld", int'(s_vld), 0);
    check("post_rst_count", int'(s_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
